// File: rtl/wb_pkg.sv
// wb_pkg: shared constants for the writeback-stage controller.
//   Opcode encodings (4-bit ISA) and the default / typical no-writeback masks.
package wb_pkg;

  localparam logic [3:0] WB_OP_LOAD  = 4'b0000;
  localparam logic [3:0] WB_OP_ALU   = 4'b0001;
  localparam logic [3:0] WB_OP_STORE = 4'b0010;
  localparam logic [3:0] WB_OP_BR    = 4'b1100;
  localparam logic [3:0] WB_OP_NOP   = 4'b1111;

  // Bit k set => opcode k never writes the register file.
  localparam logic [15:0] WB_NOWB_DEFAULT = 16'h0000;
  localparam logic [15:0] WB_NOWB_BR_NOP  = 16'h9000;  // branch + nop

endpackage

// File: rtl/wb_fwd_history.sv
// wb_fwd_history: shift history of committed RF writes plus a dual
// forwarding query port.
//   clock, reset       : rising-edge clock, async active-high reset
//   cur_v/rd/data      : write currently in the stage (youngest candidate)
//   kill               : stage is being flushed; push an empty entry instead
//   q_ra, q_rb         : query addresses
//   hit_*, data_*      : youngest matching write (stage, then entry0..N-1)
module wb_fwd_history #(
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned RA_W      = 3,
  parameter int unsigned DW        = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cur_v,
  input  logic [RA_W-1:0] cur_rd,
  input  logic [DW-1:0]   cur_data,
  input  logic            kill,
  input  logic [RA_W-1:0] q_ra,
  input  logic [RA_W-1:0] q_rb,
  output logic            hit_a,
  output logic            hit_b,
  output logic [DW-1:0]   data_a,
  output logic [DW-1:0]   data_b
);

  logic [FWD_DEPTH-1:0]           h_v;
  logic [FWD_DEPTH-1:0][RA_W-1:0] h_rd;
  logic [FWD_DEPTH-1:0][DW-1:0]   h_data;

  // Invalid entries shift like valid ones so age is purely positional.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_v    <= '0;
      h_rd   <= '0;
      h_data <= '0;
    end else begin
      h_v[0]    <= cur_v & ~kill;
      h_rd[0]   <= cur_rd;
      h_data[0] <= cur_data;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        h_v[i]    <= h_v[i-1];
        h_rd[i]   <= h_rd[i-1];
        h_data[i] <= h_data[i-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    data_a = '0;
    data_b = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (h_v[i] && h_rd[i] == q_ra) begin
        hit_a  = 1'b1;
        data_a = h_data[i];
      end
      if (h_v[i] && h_rd[i] == q_rb) begin
        hit_b  = 1'b1;
        data_b = h_data[i];
      end
    end
    if (cur_v && cur_rd == q_ra) begin
      hit_a  = 1'b1;
      data_a = cur_data;
    end
    if (cur_v && cur_rd == q_rb) begin
      hit_b  = 1'b1;
      data_b = cur_data;
    end
  end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: writeback-stage controller.
//   clock, reset          : rising-edge clock, async active-high reset
//   in_valid/op/rd/alu/mem: instruction leaving the memory stage
//   flush                 : kill staged and incoming instruction
//   rf_write/reg_in/rf_waddr/rf_wdata : register-file write port (registered)
//   q_ra, q_rb / fwd_*    : forwarding lookup against stage + history
//   retired               : wrapping count of instructions leaving the stage
module wb_ctrl_pipe
  import wb_pkg::*;
#(
  parameter int unsigned          OP_W      = 4,
  parameter int unsigned          RA_W      = 3,
  parameter int unsigned          DW        = 16,
  parameter int unsigned          OP_LOAD   = WB_OP_LOAD,
  parameter int unsigned          OP_STORE  = WB_OP_STORE,
  parameter logic [(2**OP_W)-1:0] NOWB_MASK = '0,
  parameter bit                   R0_ZERO   = 1'b1,
  parameter int unsigned          FWD_DEPTH = 2,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [DW-1:0]    in_alu,
  input  logic [DW-1:0]    in_mem,
  input  logic             flush,
  output logic             rf_write,
  output logic             reg_in,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  input  logic [RA_W-1:0]  q_ra,
  input  logic [RA_W-1:0]  q_rb,
  output logic             fwd_hit_a,
  output logic             fwd_hit_b,
  output logic [DW-1:0]    fwd_data_a,
  output logic [DW-1:0]    fwd_data_b,
  output logic [CNT_W-1:0] retired
);

  localparam logic [OP_W-1:0] LD = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] ST = OP_W'(OP_STORE);

  logic            st_valid;
  logic [OP_W-1:0] st_op;
  logic [RA_W-1:0] st_rd;
  logic [DW-1:0]   st_data;
  logic            wr;
  logic            raw_hit_a, raw_hit_b;

  // Data is selected at capture so rf_wdata is a plain register output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_valid <= 1'b0;
      st_op    <= '0;
      st_rd    <= '0;
      st_data  <= '0;
    end else begin
      st_valid <= in_valid & ~flush;
      st_op    <= in_op;
      st_rd    <= in_rd;
      st_data  <= (in_op == LD) ? in_mem : in_alu;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   retired <= '0;
    else if (st_valid && !flush) retired <= retired + CNT_W'(1);
  end

  assign wr = st_valid && (st_op != ST) && !NOWB_MASK[st_op] &&
              !(R0_ZERO && st_rd == '0);

  assign rf_write = wr;
  // Stores also drive the memory-bus select.
  assign reg_in   = st_valid && (st_op == LD || st_op == ST);
  assign rf_waddr = st_rd;
  assign rf_wdata = st_data;

  wb_fwd_history #(
    .FWD_DEPTH (FWD_DEPTH),
    .RA_W      (RA_W),
    .DW        (DW)
  ) u_hist (
    .clock    (clock),
    .reset    (reset),
    .cur_v    (wr),
    .cur_rd   (st_rd),
    .cur_data (st_data),
    .kill     (flush),
    .q_ra     (q_ra),
    .q_rb     (q_rb),
    .hit_a    (raw_hit_a),
    .hit_b    (raw_hit_b),
    .data_a   (fwd_data_a),
    .data_b   (fwd_data_b)
  );

  // r0 is hard-wired zero: never forward it even if a stale entry matches.
  assign fwd_hit_a = raw_hit_a && !(R0_ZERO && q_ra == '0);
  assign fwd_hit_b = raw_hit_b && !(R0_ZERO && q_rb == '0);

endmodule
